// File: rtl/fp_normalizer.sv
// Post-add/sub normalizer: IDLE -> SHIFT -> DONE handshake around a 1-bit iterative shifter,
// or a single-cycle leading-zero count + barrel shift when NORM_FAST_EN is defined.
module fp_normalizer #(
  parameter int FRAC_W = 27,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC_W:0]   frac_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W-1:0] frac_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              zero,
  output logic              overflow,
  output logic              subnormal
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  state_t              state, state_nxt;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic                zero_q, zero_d, ovf_q, ovf_d, sub_q, sub_d;
  logic [EXP_W:0]      exp_inc;

`ifdef NORM_FAST_EN
  logic [EXP_W:0]      lzc, exp_room;

  function automatic logic [EXP_W:0] count_lz(input logic [FRAC_W-1:0] f);
    logic [EXP_W:0] cnt;
    cnt = (EXP_W+1)'(FRAC_W);
    // Scan upward so the highest set bit wins.
    for (int i = 0; i < FRAC_W; i++)
      if (f[i]) cnt = (EXP_W+1)'(FRAC_W - 1 - i);
    return cnt;
  endfunction

  assign lzc      = count_lz(frac_q);
  assign exp_room = {1'b0, exp_q} - 1'b1;
`endif

  assign exp_inc = {1'b0, exp_in} + 1'b1;

  always_comb begin
    state_nxt = state;
    frac_d    = frac_q;
    exp_d     = exp_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    sub_d     = sub_q;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          zero_d    = 1'b0;
          ovf_d     = 1'b0;
          sub_d     = 1'b0;
          state_nxt = SHIFT;
          if (frac_in[FRAC_W]) begin
            // Carry renormalization keeps the dropped bits in the sticky position.
            frac_d = {frac_in[FRAC_W:2], |frac_in[1:0]};
            if (exp_inc >= EXP_MAX) begin
              exp_d = EXP_MAX[EXP_W-1:0];
              ovf_d = 1'b1;
            end else begin
              exp_d = exp_inc[EXP_W-1:0];
            end
          end else begin
            frac_d = frac_in[FRAC_W-1:0];
            exp_d  = exp_in;
          end
        end
      end
      SHIFT: begin
        if (frac_q == '0) begin
          zero_d    = 1'b1;
          exp_d     = '0;
          state_nxt = DONE;
        end else if (frac_q[FRAC_W-1]) begin
          state_nxt = DONE;
        end else if (exp_q <= EXP_W'(1)) begin
          exp_d     = '0;
          sub_d     = 1'b1;
          state_nxt = DONE;
        end else begin
`ifdef NORM_FAST_EN
          // Shift as far as the exponent floor allows; hitting the floor first is subnormal.
          state_nxt = DONE;
          if (lzc > exp_room) begin
            frac_d = frac_q << exp_room;
            exp_d  = '0;
            sub_d  = 1'b1;
          end else begin
            frac_d = frac_q << lzc;
            exp_d  = exp_q - lzc[EXP_W-1:0];
          end
`else
          frac_d = {frac_q[FRAC_W-2:0], 1'b0};
          exp_d  = exp_q - 1'b1;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      frac_q <= '0;
      exp_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      sub_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      frac_q <= frac_d;
      exp_q  <= exp_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      sub_q  <= sub_d;
    end
  end

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign frac_out  = frac_q;
  assign exp_out   = exp_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign subnormal = sub_q;

endmodule
